// File: rtl/alu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// alu_pipe_ctrl
//
// Two-stage valid/ready wrapper around an external combinational 32-bit ALU.
// S1 (issue) registers the operands and select and drives the ALU inputs.
// S2 (writeback) captures the ALU result and flags and presents them
// downstream, holding them stable under backpressure. A wrapping counter
// tracks retired operations.
//
// Optional feature macro: ALU_PIPE_STICKY_EN
//   defined   -> sticky_flags accumulates the OR of every retired flag vector,
//                cleared by clr_sticky (a retire in the same cycle still lands)
//   undefined -> sticky_flags is tied to 0 and clr_sticky is ignored
//
// Parameters
//   CNT_W         width of the retired-operation counter
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      upstream operation valid
//   in_ready      block can accept an operation (combinational on out_ready)
//   in_a, in_b    operands
//   in_sel        ALU operation select
//   alu_a, alu_b  registered operands to the ALU
//   alu_sel       registered operation select to the ALU
//   alu_out       ALU result
//   alu_flags     ALU flags {underflow, overflow, negative, zero, carry}
//   out_valid     registered result valid
//   out_ready     downstream accepts result
//   out_result    registered result
//   out_flags     registered flags, same packing as alu_flags
//   op_count      retired operations, wraps
//   clr_sticky    clear sticky flags
//   sticky_flags  OR of retired flags
//   busy          any stage occupied
// -----------------------------------------------------------------------------
module alu_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_sel,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_out,
  input  logic [4:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [CNT_W-1:0] op_count,
  input  logic             clr_sticky,
  output logic [4:0]       sticky_flags,
  output logic             busy
);

  // Occupancy FSM. The encoding is {s1_valid, s2_valid}, so the valid bits
  // are read straight off the state register.
  //
  //   state | meaning
  //   ------+---------------------------------------------
  //   EMPTY | no operation in flight
  //   HEAD  | result waiting in S2, S1 free
  //   ISSUE | operation in S1 at the ALU, S2 free
  //   FULL  | both stages occupied
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HEAD  = 2'b01,
    ISSUE = 2'b10,
    FULL  = 2'b11
  } occ_e;

  occ_e state_q, state_d;

  logic s1_valid;
  logic s2_valid;
  logic adv;
  logic acc;
  logic ret;

  logic [31:0] s1_a_q, s1_a_d;
  logic [31:0] s1_b_q, s1_b_d;
  logic [3:0]  s1_sel_q, s1_sel_d;
  logic [31:0] s2_res_q, s2_res_d;
  logic [4:0]  s2_flg_q, s2_flg_d;

  logic [CNT_W-1:0] op_count_q, op_count_d;

  assign s1_valid = state_q[1];
  assign s2_valid = state_q[0];

  // ---------------------------------------------------------------------------
  // Occupancy state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    adv      = 1'b0;

    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ISSUE;
        end
      end

      HEAD: begin
        // S1 is free, so a new operation can always be taken; the waiting
        // result leaves whenever downstream is ready.
        in_ready = 1'b1;
        case ({in_valid, out_ready})
          2'b11:   state_d = ISSUE;
          2'b10:   state_d = FULL;
          2'b01:   state_d = EMPTY;
          default: state_d = HEAD;
        endcase
      end

      ISSUE: begin
        // S2 is empty, so S1 always advances this cycle.
        in_ready = 1'b1;
        adv      = 1'b1;
        state_d  = in_valid ? FULL : HEAD;
      end

      FULL: begin
        // Only a retire frees S2; S1 then moves up and its slot can be
        // refilled in the same cycle.
        in_ready = out_ready;
        adv      = out_ready;
        if (out_ready) begin
          state_d = in_valid ? FULL : HEAD;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign acc = in_valid & in_ready;
  assign ret = s2_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Payload registers: they load only on their own handshake and otherwise
  // hold, which keeps S2 stable under backpressure.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_sel_d = s1_sel_q;
    s2_res_d = s2_res_q;
    s2_flg_d = s2_flg_q;

    if (acc) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_sel_d = in_sel;
    end

    if (adv) begin
      s2_res_d = alu_out;
      s2_flg_d = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q   <= 32'd0;
      s1_b_q   <= 32'd0;
      s1_sel_q <= 4'd0;
      s2_res_q <= 32'd0;
      s2_flg_q <= 5'd0;
    end else begin
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_sel_q <= s1_sel_d;
      s2_res_q <= s2_res_d;
      s2_flg_q <= s2_flg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-operation counter, wraps naturally at 2^CNT_W
  // ---------------------------------------------------------------------------
  always_comb begin
    op_count_d = op_count_q;
    if (ret) begin
      op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky exception flags
  // ---------------------------------------------------------------------------
`ifdef ALU_PIPE_STICKY_EN
  logic [4:0] sticky_q, sticky_d;

  // Clear is applied before the OR so a flag retiring in the clear cycle
  // survives.
  always_comb begin
    sticky_d = clr_sticky ? 5'd0 : sticky_q;
    if (ret) begin
      sticky_d = sticky_d | s2_flg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 5'd0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign sticky_flags      = 5'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_a      = s1_a_q;
  assign alu_b      = s1_b_q;
  assign alu_sel    = s1_sel_q;
  assign out_valid  = s2_valid;
  assign out_result = s2_res_q;
  assign out_flags  = s2_flg_q;
  assign op_count   = op_count_q;
  assign busy       = s1_valid | s2_valid;

endmodule
